// File: rtl/sprite_regs_pkg.sv
// ============================================================================
// Module      : sprite_regs_pkg
// Description : Shared definitions for the sprite register writer: writer FSM
//               state encoding, sprite register indices and the default
//               Avalon-MM address width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_regs_pkg;

  // Default Avalon-MM address width for the sprite register block.
  localparam int AW_DEFAULT = 9;

  // Sprite register indices as seen on the Avalon-MM address bus.
  localparam int DINO_X     = 0;
  localparam int DINO_Y     = 1;
  localparam int CACTUS_X   = 2;
  localparam int CACTUS_Y   = 3;
  localparam int BIRD_X     = 4;
  localparam int BIRD_Y     = 5;
  localparam int METEOR_X   = 6;
  localparam int METEOR_Y   = 7;
  localparam int GODZILLA_X = 8;
  localparam int GODZILLA_Y = 9;

  // Writer FSM states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } writer_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_req_fifo.sv
// ============================================================================
// Module      : sprite_req_fifo
// Description : Synchronous request queue holding (address, data) pairs with
//               registered occupancy. Exposes both the head entry and the
//               entry behind it so the writer can chain transfers without a
//               bubble.
// Ports       : clk, reset        - clock, async active-high reset
//               push, push_addr,
//               push_data         - enqueue request (ignored when full)
//               pop               - dequeue head (ignored when empty)
//               head_addr/data    - oldest entry
//               next_addr/data    - entry after the head
//               full, empty       - flags from registered occupancy
//               count             - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_req_fifo
  import sprite_regs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [31:0]              head_data,
  output logic [AW-1:0]            next_addr,
  output logic [31:0]              next_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);

  logic [AW-1:0]    r_mem_addr [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic               w_push_en;
  logic               w_pop_en;
  logic [c_PTR_W-1:0] w_rd_next;

  // Flags come from the registered count only, so a push while full is
  // refused even if a pop happens on the same edge.
  assign full      = (r_count == c_DEPTH_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;

  // Pointers are c_PTR_W bits wide, so the increment wraps modulo DEPTH.
  assign w_rd_next = r_rd_ptr + 1'b1;

  assign head_addr = r_mem_addr[r_rd_ptr];
  assign head_data = r_mem_data[r_rd_ptr];
  assign next_addr = r_mem_addr[w_rd_next];
  assign next_data = r_mem_data[w_rd_next];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= w_rd_next;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem_addr[r_wr_ptr] <= push_addr;
      r_mem_data[r_wr_ptr] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_avmm_writer.sv
// ============================================================================
// Module      : sprite_avmm_writer
// Description : Queues sprite register-write requests and issues them as
//               Avalon-MM master writes, one per cycle at zero wait states.
//               Optional macro VBLANK_SYNC_EN: new transfers only start while
//               vblank is high; a stalled write still finishes.
// Ports       : clk, reset                 - clock, async active-high reset
//               req_valid/ready/addr/data  - request push interface
//               vblank                     - vertical blanking indicator
//               avm_*                      - Avalon-MM master write port
//               wr_count                   - completed writes (wrapping)
//               busy                       - queue non-empty or writing
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_avmm_writer
  import sprite_regs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  input  logic          vblank,
  output logic [AW-1:0] avm_address,
  output logic [31:0]   avm_writedata,
  output logic          avm_write,
  output logic          avm_chipselect,
  input  logic          avm_waitrequest,
  output logic [15:0]   wr_count,
  output logic          busy
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  writer_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_avm_address, w_addr_nxt;
  logic [31:0]   r_avm_writedata, w_data_nxt;
  logic [15:0]   r_wr_count;

  logic               w_pop;
  logic               w_gate;
  logic               w_full;
  logic               w_empty;
  logic [c_CNT_W-1:0] w_count;
  logic [AW-1:0]      w_head_addr, w_next_addr;
  logic [31:0]        w_head_data, w_next_data;
  logic               w_more;

`ifdef VBLANK_SYNC_EN
  assign w_gate = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_gate          = 1'b1;
`endif

  sprite_req_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_addr (req_addr),
    .push_data (req_data),
    .pop       (w_pop),
    .head_addr (w_head_addr),
    .head_data (w_head_data),
    .next_addr (w_next_addr),
    .next_data (w_next_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // The entry being written stays at the FIFO head until it completes, so
  // a chained transfer needs a second entry behind it.
  assign w_more = (w_count > c_CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
      r_wr_count      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_avm_address   <= w_addr_nxt;
      r_avm_writedata <= w_data_nxt;
      if (w_pop) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_avm_address;
    w_data_nxt  = r_avm_writedata;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && w_gate) begin
          w_state_nxt = ST_WRITE;
          w_addr_nxt  = w_head_addr;
          w_data_nxt  = w_head_data;
        end
      end
      ST_WRITE: begin
        // While stalled everything holds; on completion either chain the
        // next entry or fall back to IDLE.
        if (!avm_waitrequest) begin
          w_pop = 1'b1;
          if (w_more && w_gate) begin
            w_addr_nxt = w_next_addr;
            w_data_nxt = w_next_data;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them
  // without waiting for a clock edge.
  assign avm_write      = (r_state == ST_WRITE);
  assign avm_chipselect = (r_state == ST_WRITE);
  assign avm_address    = r_avm_address;
  assign avm_writedata  = r_avm_writedata;
  assign wr_count       = r_wr_count;
  assign req_ready      = !w_full;
  assign busy           = !w_empty || (r_state == ST_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_sprite_avmm_writer.sv
// ============================================================================
// Module      : tb_sprite_avmm_writer
// Description : Self-checking bench for sprite_avmm_writer. Directed steps
//               push requests; a scoreboard queue holds the expected write
//               order and is checked whenever a write completes.
//               Honours VBLANK_SYNC_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_avmm_writer;
  import sprite_regs_pkg::*;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_addr;
  logic [31:0] req_data;
  logic        vblank;
  logic [8:0]  avm_address;
  logic [31:0] avm_writedata;
  logic        avm_write;
  logic        avm_chipselect;
  logic        avm_waitrequest;
  logic [15:0] wr_count;
  logic        busy;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   wr_seen = 0;

  sprite_avmm_writer #(
    .DEPTH (4),
    .AW    (9)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .vblank          (vblank),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_write       (avm_write),
    .avm_chipselect  (avm_chipselect),
    .avm_waitrequest (avm_waitrequest),
    .wr_count        (wr_count),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request over a single edge; it is expected to be accepted.
  task automatic push(input logic [8:0] a, input logic [31:0] d, input string tag);
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    check(tag, {31'd0, req_ready}, 32'd1);
    e.addr = a;
    e.data = d;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  // Scoreboard: every completed write must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && avm_write && !avm_waitrequest) begin
      wr_seen++;
      checks++;
      assert (sb.size() != 0) passes++;
      else $error("FAIL sb_extra_write: observed addr 0x%0h expected no write", avm_address);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_addr", {23'd0, avm_address}, {23'd0, e.addr});
        check("sb_data", avm_writedata, e.data);
        check("sb_cs", {31'd0, avm_chipselect}, 32'd1);
      end
    end
  end

  initial begin
    int seen0;
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_addr        = '0;
    req_data        = '0;
    vblank          = 1'b1;
    avm_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_write", {31'd0, avm_write}, 32'd0);
    check("rst_cs", {31'd0, avm_chipselect}, 32'd0);
    check("rst_addr", {23'd0, avm_address}, 32'd0);
    check("rst_data", avm_writedata, 32'd0);
    check("rst_wrcnt", {16'd0, wr_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // Single write, two-cycle latency
    push(DINO_X[8:0], 32'h64, "single_ready");
    check("single_lat0", {31'd0, avm_write}, 32'd0);
    tick();
    check("single_write", {31'd0, avm_write}, 32'd1);
    check("single_addr", {23'd0, avm_address}, 32'd0);
    check("single_data", avm_writedata, 32'h64);
    tick();
    check("single_done", {31'd0, avm_write}, 32'd0);
    check("single_wrcnt", {16'd0, wr_count}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd0);

    // Four back-to-back requests, one write per cycle
    for (int i = 0; i < 4; i++) push(9'(i), 32'h10 + 32'(i), "b2b_ready");
    check("b2b_wrcnt_e4", {16'd0, wr_count}, 32'd3);
    check("b2b_write_e4", {31'd0, avm_write}, 32'd1);
    check("b2b_ready_e4", {31'd0, req_ready}, 32'd1);
    tick();
    check("b2b_wrcnt_e5", {16'd0, wr_count}, 32'd4);
    tick();
    check("b2b_wrcnt_e6", {16'd0, wr_count}, 32'd5);
    check("b2b_idle", {31'd0, avm_write}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd0);

    // Three stall cycles: outputs held for four cycles, one completion
    avm_waitrequest = 1'b1;
    push(METEOR_X[8:0], 32'h1F4 & 32'hFF, "stall_ready");
    check("stall_lat0", {31'd0, avm_write}, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("stall_hold_wr", {31'd0, avm_write}, 32'd1);
      check("stall_hold_addr", {23'd0, avm_address}, 32'd6);
      check("stall_hold_data", avm_writedata, 32'hF4);
      check("stall_hold_cnt", {16'd0, wr_count}, 32'd5);
      tick();
    end
    avm_waitrequest = 1'b0;
    check("stall_hold4_wr", {31'd0, avm_write}, 32'd1);
    check("stall_hold4_addr", {23'd0, avm_address}, 32'd6);
    tick();
    check("stall_done", {31'd0, avm_write}, 32'd0);
    check("stall_wrcnt", {16'd0, wr_count}, 32'd6);

    // Fill while stalled, then push into a full FIFO with a concurrent pop
    avm_waitrequest = 1'b1;
    for (int i = 1; i <= 4; i++) push(9'(i), 32'hA0 + 32'(i), "full_fill_ready");
    check("full_ready", {31'd0, req_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    req_valid       = 1'b1;
    req_addr        = 9'd5;
    req_data        = 32'hA5;
    avm_waitrequest = 1'b0;
    tick();
    check("full_refused_cnt", {16'd0, wr_count}, 32'd7);
    check("full_ready_after_pop", {31'd0, req_ready}, 32'd1);
    sb.push_back(exp_t'{addr: 9'd5, data: 32'hA5});
    tick();
    req_valid = 1'b0;
    check("full_accept_cnt", {16'd0, wr_count}, 32'd8);
    repeat (3) tick();
    check("full_drain_cnt", {16'd0, wr_count}, 32'd11);
    check("full_drain_idle", {31'd0, avm_write}, 32'd0);

`ifdef VBLANK_SYNC_EN
    // Writes wait for vblank, then issue back-to-back
    vblank = 1'b0;
    push(GODZILLA_X[8:0], 32'h21, "vb_ready0");
    push(GODZILLA_Y[8:0], 32'h22, "vb_ready1");
    repeat (3) tick();
    check("vb_blocked_wr", {31'd0, avm_write}, 32'd0);
    check("vb_blocked_cnt", {16'd0, wr_count}, 32'd11);
    check("vb_blocked_busy", {31'd0, busy}, 32'd1);
    vblank = 1'b1;
    tick();
    check("vb_first", {31'd0, avm_write}, 32'd1);
    tick();
    check("vb_second", {31'd0, avm_write}, 32'd1);
    tick();
    check("vb_done", {31'd0, avm_write}, 32'd0);
    check("vb_wrcnt", {16'd0, wr_count}, 32'd13);
`else
    // vblank has no effect in the default build
    vblank = 1'b0;
    push(GODZILLA_Y[8:0], 32'h22, "novb_ready");
    tick();
    check("novb_write", {31'd0, avm_write}, 32'd1);
    tick();
    check("novb_wrcnt", {16'd0, wr_count}, 32'd12);
    vblank = 1'b1;
`endif

    // Reset during a stalled write with three more queued
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) push(9'(i), 32'hC0 + 32'(i), "rstmid_ready");
    check("rstmid_write", {31'd0, avm_write}, 32'd1);
    check("rstmid_full", {31'd0, req_ready}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("rstmid_async_wr", {31'd0, avm_write}, 32'd0);
    check("rstmid_async_cs", {31'd0, avm_chipselect}, 32'd0);
    check("rstmid_async_cnt", {16'd0, wr_count}, 32'd0);
    check("rstmid_async_busy", {31'd0, busy}, 32'd0);
    check("rstmid_async_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_async_addr", {23'd0, avm_address}, 32'd0);
    sb.delete();
    seen0 = wr_seen;
    @(posedge clk);
    #2;
    reset           = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (5) tick();
    check("rstpost_wr", {31'd0, avm_write}, 32'd0);
    check("rstpost_cnt", {16'd0, wr_count}, 32'd0);
    check("rstpost_busy", {31'd0, busy}, 32'd0);
    check("rstpost_seen", 32'(wr_seen), 32'(seen0));

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_avmm_writer.md
SPRITE_AVMM_WRITER -- requirements
Module: sprite_avmm_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO depth; power of two, 2..16.
REQ-002 SHALL have parameter AW, default 9, Avalon-MM address width.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  producer has a register-write request.
REQ-006 SHALL have port req_ready  output  1  FIFO can accept a request.
REQ-007 SHALL have port req_addr  input  AW  target register index (0 dino_x ... 9 godzilla_y).
REQ-008 SHALL have port req_data  input  32  value to write; sprite registers use bits [7:0].
REQ-009 SHALL have port vblank  input  1  high during display vertical blanking.
REQ-010 SHALL have port avm_address  output  AW  Avalon-MM master address.
REQ-011 SHALL have port avm_writedata  output  32  Avalon-MM master write data.
REQ-012 SHALL have port avm_write  output  1  Avalon-MM write strobe.
REQ-013 SHALL have port avm_chipselect  output  1  Avalon-MM chip select; equals avm_write.
REQ-014 SHALL have port avm_waitrequest  input  1  slave stall; tie 0 for zero-wait slaves.
REQ-015 SHALL have port wr_count  output  16  completed writes since reset, wraps at 65535->0.
REQ-016 SHALL have port busy  output  1  FIFO non-empty or transfer in progress.

Function
REQ-017 SHALL push req_addr/req_data when req_valid && req_ready on a rising edge.
REQ-018 SHALL drive req_ready = (occupancy < DEPTH), from registered occupancy; a push while full SHALL be refused even when a pop occurs in the same cycle.
REQ-019 SHALL run FSM IDLE -> WRITE: leave IDLE on the edge after FIFO non-empty (and gate open, REQ-029); enter WRITE with head entry registered onto avm_address/avm_writedata.
REQ-020 SHALL hold avm_write, avm_chipselect, avm_address, avm_writedata stable in WRITE while avm_waitrequest = 1.
REQ-021 SHALL complete a transfer on the edge where avm_write && !avm_waitrequest: pop FIFO, increment wr_count.
REQ-022 SHALL, on completion with FIFO still non-empty (and gate open), present next entry the following cycle with avm_write kept high (back-to-back, one write per cycle at zero wait); else return to IDLE with avm_write = 0.
REQ-023 SHALL allow push and pop in the same cycle when not full; occupancy unchanged.
REQ-024 SHALL issue writes in strict FIFO order; never drop or duplicate an accepted request.
REQ-025 SHALL keep first-write latency 2 cycles: push at edge N -> avm_write high after edge N+1.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-027 SHALL, on reset, asynchronously clear: FSM to IDLE, FIFO empty, avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, wr_count=0, busy=0, req_ready=1.
REQ-028 SHALL, on reset mid-transfer, abort the write immediately, discarding all queued requests.

Configuration
REQ-029 With VBLANK_SYNC_EN defined SHALL start a new transfer (IDLE->WRITE or back-to-back) only while vblank = 1; an in-flight stalled write SHALL finish regardless of vblank; without the macro vblank SHALL be ignored.

Structure
REQ-030 SHALL place FSM state enum, register index constants (DINO_X=0 ... GODZILLA_Y=9) and AW default in shared package sprite_regs_pkg.
REQ-031 SHALL implement the queue as sub-module sprite_req_fifo (synchronous, registered occupancy, full/empty flags).

Verification
REQ-032 Single push addr=0 data=0x64, waitrequest=0 -> one avm_write cycle 2 cycles later, address 0, writedata 0x64, wr_count=1.
REQ-033 Push 4 entries back-to-back (addr 0..3), waitrequest=0 -> 4 consecutive write cycles in order, req_ready low only when occupancy 4.
REQ-034 waitrequest high 3 cycles on addr=6 data=0x1F4&0xFF -> signals held 4 cycles, single completion, wr_count +1.
REQ-035 Push 5th while full with concurrent pop -> refused (req_ready=0), accepted next cycle.
REQ-036 VBLANK_SYNC_EN, push 2 entries while vblank=0 -> no writes; vblank rises -> 2 writes back-to-back.
REQ-037 Assert reset during stalled write with 3 queued -> avm_write=0 same cycle, wr_count=0, no writes after release.
